// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants for the hazard controller.
package core_pkg;

  // Default width of the stall-cycle counter.
  localparam int CNT_W_DEFAULT = 16;

  // MDU sequencing state: RUN lets the pipeline flow; MDU_WAIT holds it for a mul/div.
  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance only while enabled and not already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait, multi-cycle MDU sequencing,
// taken-branch flush and load-use interlock, resolved in that priority order.
//
// MDU protocol: mdu_start is a single-cycle launch pulse issued from RUN;
// mdu_done is a single-cycle completion pulse. A pulse landing while the
// pipeline is frozen by a memory wait is remembered in done_q so it is
// never lost. state_dbg exposes the FSM (1 = MDU_WAIT).
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             load_ex,
  input  logic             br_taken_ex,
  input  logic             mdu_req_ex,
  input  logic             mdu_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             bubble_wb,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             state_dbg
);

  hazard_state_t state_q, state_d;
  logic          done_q, done_d;

  logic mem_wait;
  logic load_use;
  logic done_obs;

  assign mem_wait = dmem_req_mem && !dmem_ready;
  assign load_use = load_ex && (rd_ex != 5'd0) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));
  assign done_obs = mdu_done || done_q;

  // Next state and all pipeline-control outputs; everything is forced low in reset.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush_id   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    bubble_wb  = 1'b0;
    mdu_start  = 1'b0;
    if (arst_n) begin
      if (mem_wait) begin
        // Whole pipeline frozen; only capture an MDU completion for later.
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        bubble_wb = 1'b1;
        if ((state_q == MDU_WAIT) && mdu_done) begin
          done_d = 1'b1;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (mdu_req_ex) begin
              // Launch takes precedence over a branch resolving in the same slot.
              mdu_start  = 1'b1;
              stall_if   = 1'b1;
              stall_id   = 1'b1;
              stall_ex   = 1'b1;
              bubble_mem = 1'b1;
              state_d    = MDU_WAIT;
            end else if (br_taken_ex) begin
              // Wrong-path instruction in ID is discarded, so its load-use is moot.
              flush_id  = 1'b1;
              bubble_ex = 1'b1;
            end else if (load_use) begin
              stall_if  = 1'b1;
              stall_id  = 1'b1;
              bubble_ex = 1'b1;
            end
          end
          MDU_WAIT: begin
            if (done_obs) begin
              state_d = RUN;
              done_d  = 1'b0;
            end else begin
              stall_if   = 1'b1;
              stall_id   = 1'b1;
              stall_ex   = 1'b1;
              bubble_mem = 1'b1;
            end
          end
          default: begin
            state_d = RUN;
            done_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // FSM state and sticky MDU-done flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign state_dbg = (state_q == MDU_WAIT);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .arst_n  (arst_n),
    .en_i    (stall_if),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4). Each driven cycle pushes its
// hand-computed expected observation; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int CW = 4;
  localparam int OW = 10 + CW;

  logic          clk;
  logic          arst_n;
  logic [4:0]    rs1_id, rs2_id, rd_ex;
  logic          rs1_used_id, rs2_used_id;
  logic          load_ex, br_taken_ex, mdu_req_ex, mdu_done;
  logic          dmem_req_mem, dmem_ready;
  logic          stall_if, stall_id, stall_ex, stall_mem;
  logic          flush_id, bubble_ex, bubble_mem, bubble_wb, mdu_start;
  logic [CW-1:0] stall_cnt;
  logic          state_dbg;

  // Observation order: si sd se sm fl bex bm bwb ms st | cnt
  logic [OW-1:0] obs;
  assign obs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
                bubble_mem, bubble_wb, mdu_start, state_dbg, stall_cnt};

  localparam logic [9:0] F_NONE  = 10'b0000000000;
  localparam logic [9:0] F_LU    = 10'b1100010000;
  localparam logic [9:0] F_BR    = 10'b0000110000;
  localparam logic [9:0] F_LAUN  = 10'b1110001010;
  localparam logic [9:0] F_WAIT  = 10'b1110001001;
  localparam logic [9:0] F_DONE  = 10'b0000000001;
  localparam logic [9:0] F_MEMR  = 10'b1111000100;
  localparam logic [9:0] F_MEMW  = 10'b1111000101;

  logic [OW-1:0] exp_q[$];
  string         name_q[$];
  int            n_chk;
  int            n_fail;

  hazard_ctrl #(
    .CNT_W (CW)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_used_id  (rs1_used_id),
    .rs2_used_id  (rs2_used_id),
    .rd_ex        (rd_ex),
    .load_ex      (load_ex),
    .br_taken_ex  (br_taken_ex),
    .mdu_req_ex   (mdu_req_ex),
    .mdu_done     (mdu_done),
    .dmem_req_mem (dmem_req_mem),
    .dmem_ready   (dmem_ready),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush_id     (flush_id),
    .bubble_ex    (bubble_ex),
    .bubble_mem   (bubble_mem),
    .bubble_wb    (bubble_wb),
    .mdu_start    (mdu_start),
    .stall_cnt    (stall_cnt),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags=%b cnt=%0d, required flags=%b cnt=%0d",
               name, act[OW-1:CW], act[CW-1:0], exp[OW-1:CW], exp[CW-1:0]);
    end
  endtask

  // Monitor: compare every observed cycle that has an expectation queued
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), obs, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic idle();
    rs1_id       = 5'd0;
    rs2_id       = 5'd0;
    rs1_used_id  = 1'b0;
    rs2_used_id  = 1'b0;
    rd_ex        = 5'd0;
    load_ex      = 1'b0;
    br_taken_ex  = 1'b0;
    mdu_req_ex   = 1'b0;
    mdu_done     = 1'b0;
    dmem_req_mem = 1'b0;
    dmem_ready   = 1'b1;
  endtask

  task automatic load_use_in();
    load_ex     = 1'b1;
    rd_ex       = 5'd5;
    rs2_id      = 5'd5;
    rs2_used_id = 1'b1;
  endtask

  task automatic mem_stall_in();
    dmem_req_mem = 1'b1;
    dmem_ready   = 1'b0;
  endtask

  // Inputs already applied; queue expectation, advance one cycle.
  task automatic step(input string name, input logic [9:0] fl, input int cnt);
    logic [CW-1:0] c;
    c = cnt[CW-1:0];
    exp_q.push_back({fl, c});
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    mdu_req_ex = 1'b1;
    br_taken_ex = 1'b1;
    arst_n = 1'b0;
    #2;
    check("reset_outputs_low", obs, '0);
    repeat (3) @(posedge clk);
    #1;
    idle();
    arst_n = 1'b1;

    step("idle_after_reset", F_NONE, 0);

    // Load-use on rs2
    idle(); load_use_in();
    step("load_use_rs2", F_LU, 0);
    idle();
    step("load_use_release", F_NONE, 1);

    // rd_ex == x0 never interlocks
    idle(); load_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1;
    step("load_x0_no_stall", F_NONE, 1);
    // matching source that is not read
    idle(); load_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b0;
    step("unused_src_no_stall", F_NONE, 1);
    // matching rs1 that is read
    idle(); load_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; rs1_used_id = 1'b1;
    step("load_use_rs1", F_LU, 1);

    // Branch masks load-use
    idle(); load_use_in(); br_taken_ex = 1'b1;
    step("branch_masks_lu", F_BR, 2);
    idle();
    step("after_branch", F_NONE, 2);

    // MDU launch (branch ignored), 3 wait cycles, done on the 4th
    idle(); mdu_req_ex = 1'b1; br_taken_ex = 1'b1;
    step("mdu_launch", F_LAUN, 2);
    br_taken_ex = 1'b0;
    step("mdu_wait1", F_WAIT, 3);
    step("mdu_wait2", F_WAIT, 4);
    step("mdu_wait3", F_WAIT, 5);
    mdu_req_ex = 1'b0; mdu_done = 1'b1;
    step("mdu_done_release", F_DONE, 6);
    idle();
    step("mdu_back_run", F_NONE, 6);

    // Stray done in RUN
    idle(); mdu_done = 1'b1;
    step("stray_done_run", F_NONE, 6);
    idle();
    step("stray_done_after", F_NONE, 6);

    // Done arriving during memory wait
    idle(); mdu_req_ex = 1'b1;
    step("mdu_launch2", F_LAUN, 6);
    idle(); mem_stall_in();
    step("memwait_c1", F_MEMW, 7);
    mdu_done = 1'b1;
    step("memwait_c2_done", F_MEMW, 8);
    mdu_done = 1'b0;
    step("memwait_c3", F_MEMW, 9);
    idle();
    step("sticky_done_release", F_DONE, 10);
    step("sticky_back_run", F_NONE, 10);

    // Memory wait overrides load-use and MDU launch
    idle(); mem_stall_in(); load_use_in();
    step("memwait_over_lu", F_MEMR, 10);
    idle(); mem_stall_in(); mdu_req_ex = 1'b1;
    step("memwait_over_launch", F_MEMR, 11);
    idle();
    step("no_launch_after_mem", F_NONE, 12);

    // Saturation at 15
    for (int i = 0; i < 20; i++) begin
      idle(); load_use_in();
      step("saturate_loop", F_LU, (12 + i > 15) ? 15 : 12 + i);
    end
    idle();
    step("saturated_hold", F_NONE, 15);

    // Reset in MDU_WAIT
    idle(); mdu_req_ex = 1'b1;
    step("mdu_launch3", F_LAUN, 15);
    idle();
    step("mdu_wait_pre_reset", F_WAIT, 15);
    #2;
    arst_n = 1'b0;
    #1;
    check("async_reset_in_wait", obs, '0);
    @(posedge clk);
    #1;
    check("reset_held", obs, '0);
    arst_n = 1'b1;
    mdu_done = 1'b1;
    step("stray_done_post_reset", F_NONE, 0);
    idle();
    step("idle_post_reset", F_NONE, 0);

    @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
